// File: rtl/dm_pkg.sv
// Shared constants and types for the data-memory arbiter.
package dm_pkg;

  localparam int ADDR_W       = 12;
  localparam int DATA_W       = 64;
  localparam int DEPTH        = 512;
  localparam int LOCK_MAX_DEF = 8;

  // Requester identifier: one bit selects between the two ports.
  typedef logic port_id_t;

  localparam port_id_t PORT_CPU = 1'b0;
  localparam port_id_t PORT_DBG = 1'b1;

  // True when a word address falls inside the implemented memory.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_W'(DEPTH);
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester and memory-side signal bundle for dm_arbiter.
// slave  : the arbiter's view.
// master : the view of whoever drives requests and models the memory.
interface dm_arbiter_if;
  import dm_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] dm_address;
  logic [DATA_W-1:0] dm_data_write;
  logic              dm_write_enable;
  logic [DATA_W-1:0] dm_data_read;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  dm_data_read,
    output gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
    output dm_address, dm_data_write, dm_write_enable
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output dm_data_read,
    input  gnt0, gnt1, rvalid0, rvalid1, err0, err1, rdata0, rdata1,
    input  dm_address, dm_data_write, dm_write_enable
  );

endinterface

// File: rtl/dm_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with a bounded burst lock.
// A port that was granted with its lock bit high keeps the grant while it
// keeps requesting, up to LOCK_MAX extra grants; after that the other port
// gets through if it is waiting. A lone requester is always served.
module rr_arb2
  import dm_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o,
  output port_id_t   winner_o
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  port_id_t         last_winner_q, last_winner_d;
  logic             lock_pend_q, lock_pend_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             hold;
  logic             any_gnt;

  // Grant selection and next arbitration state.
  always_comb begin
    gnt_o         = '0;
    winner_o      = last_winner_q;
    any_gnt       = 1'b0;
    last_winner_d = last_winner_q;
    lock_pend_d   = 1'b0;
    lock_cnt_d    = '0;
    hold          = lock_pend_q & req_i[last_winner_q] & (lock_cnt_q < LOCK_MAX_C);

    // Nothing may be granted while reset is asserted, so nothing gets staged.
    if (!reset) begin
      if (hold) begin
        winner_o = last_winner_q;
        any_gnt  = 1'b1;
      end else if (&req_i) begin
        winner_o = ~last_winner_q;
        any_gnt  = 1'b1;
      end else if (req_i[PORT_CPU]) begin
        winner_o = PORT_CPU;
        any_gnt  = 1'b1;
      end else if (req_i[PORT_DBG]) begin
        winner_o = PORT_DBG;
        any_gnt  = 1'b1;
      end
    end

    if (any_gnt) begin
      gnt_o[winner_o] = 1'b1;
      last_winner_d   = winner_o;
      lock_pend_d     = lock_i[winner_o];
      // Count only re-grants that follow a locked grant; saturate at the limit
      // so a lone locked requester keeps its count pinned.
      if (lock_pend_q && (winner_o == last_winner_q)) begin
        lock_cnt_d = (lock_cnt_q == LOCK_MAX_C) ? lock_cnt_q : lock_cnt_q + 1'b1;
      end
    end
  end

  // Arbitration state register; port 0 wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_q <= PORT_DBG;
      lock_pend_q   <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      lock_pend_q   <= lock_pend_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Shares one single-port data memory between the CPU load/store path (port 0)
// and the debug/loader port (port 1). Accesses granted in one cycle are
// registered and presented to the memory in the next, where the response is
// returned combinationally from the memory read data.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic         clk,
  input  logic         reset,
  dm_arbiter_if.slave  bus
);

  logic [1:0] gnt;
  port_id_t   winner;

  logic              stage_valid_q, stage_valid_d;
  port_id_t          stage_port_q, stage_port_d;
  logic              stage_we_q, stage_we_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] stage_wdata_q, stage_wdata_d;

  logic              live;
  logic              in_range;
  logic [DATA_W-1:0] rsp_data;

  rr_arb2 #(
    .LOCK_MAX (LOCK_MAX)
  ) u_rr_arb2 (
    .clk      (clk),
    .reset    (reset),
    .req_i    ({bus.req1, bus.req0}),
    .lock_i   ({bus.lock1, bus.lock0}),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  assign bus.gnt0 = gnt[PORT_CPU];
  assign bus.gnt1 = gnt[PORT_DBG];

  // Capture the granted port's request into the access stage.
  always_comb begin
    stage_valid_d = |gnt;
    stage_port_d  = stage_port_q;
    stage_we_d    = stage_we_q;
    stage_addr_d  = stage_addr_q;
    stage_wdata_d = stage_wdata_q;
    if (|gnt) begin
      stage_port_d  = winner;
      stage_we_d    = (winner == PORT_DBG) ? bus.we1    : bus.we0;
      stage_addr_d  = (winner == PORT_DBG) ? bus.addr1  : bus.addr0;
      stage_wdata_d = (winner == PORT_DBG) ? bus.wdata1 : bus.wdata0;
    end
  end

  // Access stage register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_q <= 1'b0;
      stage_port_q  <= PORT_CPU;
      stage_we_q    <= 1'b0;
      stage_addr_q  <= '0;
      stage_wdata_q <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_port_q  <= stage_port_d;
      stage_we_q    <= stage_we_d;
      stage_addr_q  <= stage_addr_d;
      stage_wdata_q <= stage_wdata_d;
    end
  end

  // Memory drive and response. Reset masks the staged access in the same
  // cycle so an access caught by reset neither writes nor responds.
  always_comb begin
    live     = stage_valid_q & ~reset;
    in_range = addr_in_range(stage_addr_q);
    rsp_data = (live && !stage_we_q && in_range) ? bus.dm_data_read : '0;

    bus.dm_address      = stage_addr_q;
    bus.dm_data_write   = stage_wdata_q;
    bus.dm_write_enable = live & stage_we_q & in_range;

    bus.rvalid0 = live & (stage_port_q == PORT_CPU);
    bus.rvalid1 = live & (stage_port_q == PORT_DBG);
    bus.err0    = bus.rvalid0 & ~in_range;
    bus.err1    = bus.rvalid1 & ~in_range;
    bus.rdata0  = bus.rvalid0 ? rsp_data : '0;
    bus.rdata1  = bus.rvalid1 ? rsp_data : '0;
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 512 x 64 memory.
module tb_dm_arbiter;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  dm_arbiter_if bus ();

  dm_arbiter #(
    .LOCK_MAX (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: combinational read, write on enable at the clock edge.
  logic [63:0] mem [0:511];
  assign bus.dm_data_read = mem[bus.dm_address[8:0]];
  always @(posedge clk) begin
    if (bus.dm_write_enable) mem[bus.dm_address[8:0]] <= bus.dm_data_write;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0,
                       input logic [11:0] a0, input logic [63:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [11:0] a1, input logic [63:0] d1);
    bus.req0 = r0; bus.we0 = w0; bus.lock0 = l0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.lock1 = l1; bus.addr1 = a1; bus.wdata1 = d1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 12'd0, 64'd0, 0, 0, 0, 12'd0, 64'd0);
  endtask

  // Advance to the middle of the next cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    drive(1, 1, 0, 12'd3, 64'hFF, 1, 1, 0, 12'd4, 64'hEE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    // Reset state: no grants even with both requesting, memory side quiet.
    chk("rst_gnt0", bus.gnt0, 1'b0);
    chk("rst_gnt1", bus.gnt1, 1'b0);
    chk("rst_rvalid0", bus.rvalid0, 1'b0);
    chk("rst_rvalid1", bus.rvalid1, 1'b0);
    chk("rst_err0", bus.err0, 1'b0);
    chk("rst_rdata0", bus.rdata0, 64'd0);
    chk("rst_we", bus.dm_write_enable, 1'b0);
    chk("rst_addr", bus.dm_address, 12'd0);
    chk("rst_wdata", bus.dm_data_write, 64'd0);
    $display("reset state checked");

    // Preload mem[5] = A5 through port 1.
    reset = 1'b0;
    drive(0, 0, 0, 12'd0, 64'd0, 1, 1, 0, 12'd5, 64'hA5);
    #1;
    chk("pre_gnt1", bus.gnt1, 1'b1);
    chk("pre_gnt0", bus.gnt0, 1'b0);
    tick();
    idle();
    chk("pre_we", bus.dm_write_enable, 1'b1);
    chk("pre_addr", bus.dm_address, 12'd5);
    chk("pre_wdata", bus.dm_data_write, 64'hA5);
    chk("pre_rvalid1", bus.rvalid1, 1'b1);
    chk("pre_err1", bus.err1, 1'b0);
    tick();
    chk("pre_we_pulse", bus.dm_write_enable, 1'b0);
    $display("port1 write addr 5 = a5");

    // Reset pulse, then port 0 reads addr 5.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 12'd5, 64'd0, 0, 0, 0, 12'd0, 64'd0);
    #1;
    chk("rd5_gnt0", bus.gnt0, 1'b1);
    tick();
    idle();
    chk("rd5_rvalid0", bus.rvalid0, 1'b1);
    chk("rd5_rdata0", bus.rdata0, 64'hA5);
    chk("rd5_err0", bus.err0, 1'b0);
    chk("rd5_rvalid1", bus.rvalid1, 1'b0);
    $display("port0 read addr 5 rdata=%h", bus.rdata0);

    // Both requesting continuously: last winner was 0, so 1,0,1,0.
    drive(1, 0, 0, 12'd5, 64'd0, 1, 0, 0, 12'd5, 64'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_gnt1", bus.gnt1, (i % 2 == 0));
      chk("alt_gnt0", bus.gnt0, (i % 2 != 0));
      tick();
      chk("alt_rvalid1", bus.rvalid1, (i % 2 == 0));
      chk("alt_rvalid0", bus.rvalid0, (i % 2 != 0));
      chk("alt_rdata", bus.rdata0 | bus.rdata1, 64'hA5);
      $display("alternate cycle %0d gnt1=%b", i, (i % 2 == 0));
    end

    // Port 1 writes addr 10, port 0 reads it back the next cycle.
    drive(0, 0, 0, 12'd0, 64'd0, 1, 1, 0, 12'd10, 64'h1234);
    #1;
    chk("raw_gnt1", bus.gnt1, 1'b1);
    tick();
    drive(1, 0, 0, 12'd10, 64'd0, 0, 0, 0, 12'd0, 64'd0);
    chk("raw_we", bus.dm_write_enable, 1'b1);
    chk("raw_addr", bus.dm_address, 12'd10);
    #1;
    chk("raw_gnt0", bus.gnt0, 1'b1);
    tick();
    idle();
    chk("raw_we_off", bus.dm_write_enable, 1'b0);
    chk("raw_rvalid0", bus.rvalid0, 1'b1);
    chk("raw_rdata0", bus.rdata0, 64'h1234);
    $display("read-after-write addr 10 rdata=%h", bus.rdata0);

    // Locked burst on port 1 against a constant port 0: 9 grants then port 0.
    drive(1, 0, 0, 12'd5, 64'd0, 1, 0, 1, 12'd10, 64'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("lock_gnt1", bus.gnt1, (i < 9));
      chk("lock_gnt0", bus.gnt0, (i == 9));
      tick();
      $display("lock cycle %0d gnt1=%b", i, (i < 9));
    end
    idle();
    tick();

    // Out-of-range write: accepted, flagged, never reaches the memory.
    drive(1, 1, 0, 12'd600, 64'hFFFF, 0, 0, 0, 12'd0, 64'd0);
    #1;
    chk("oor_gnt0", bus.gnt0, 1'b1);
    tick();
    idle();
    chk("oor_we", bus.dm_write_enable, 1'b0);
    chk("oor_rvalid0", bus.rvalid0, 1'b1);
    chk("oor_err0", bus.err0, 1'b1);
    chk("oor_rdata0", bus.rdata0, 64'd0);
    $display("out-of-range write addr 600 err0=%b", bus.err0);
    tick();

    // Reset catches a staged write: it is dropped, old data survives.
    drive(1, 1, 0, 12'd20, 64'h1111, 0, 0, 0, 12'd0, 64'd0);
    tick();
    idle();
    tick();
    drive(1, 1, 0, 12'd20, 64'h2222, 0, 0, 0, 12'd0, 64'd0);
    #1;
    chk("rstw_gnt0", bus.gnt0, 1'b1);
    tick();
    idle();
    reset = 1'b1;
    #1;
    chk("rstw_we", bus.dm_write_enable, 1'b0);
    chk("rstw_rvalid0", bus.rvalid0, 1'b0);
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 12'd20, 64'd0, 1, 0, 0, 12'd20, 64'd0);
    #1;
    chk("rstw_tie_gnt0", bus.gnt0, 1'b1);
    chk("rstw_tie_gnt1", bus.gnt1, 1'b0);
    tick();
    idle();
    chk("rstw_rdata0", bus.rdata0, 64'h1111);
    $display("reset-dropped write addr 20 rdata=%h", bus.rdata0);
    tick();

    // Lone locked requester runs past the limit; a waiting port 0 then wins.
    drive(0, 0, 0, 12'd0, 64'd0, 1, 0, 1, 12'd5, 64'd0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("sat_gnt1", bus.gnt1, 1'b1);
      tick();
    end
    drive(1, 0, 0, 12'd5, 64'd0, 1, 0, 1, 12'd5, 64'd0);
    #1;
    chk("sat_gnt0", bus.gnt0, 1'b1);
    chk("sat_gnt1_off", bus.gnt1, 1'b0);
    tick();
    idle();
    $display("saturated lock released to port0");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
